multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the RV32I datapath. It replaces the free-running PC increment and per-cycle control with a state machine that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the datapath enables (PC, IR, register file, data memory) and holds data-memory requests until the memory acknowledges. It sits beside the datapath, takes the opcode field of the instruction register, and emits the same control signal set as the main control unit plus handshake, fault and retire outputs.

## Interface
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for ack before fault; legal range 1..255.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_Run  in  1  level; FETCH proceeds only while high.
- i_OPCode  in  7  instruction bits [6:0], valid from DECODE onward.
- i_MemAck  in  1  data-memory acknowledge, sampled in MEM.
- o_PCWrite  out  1  load PC with PC+4.
- o_PCWriteCond  out  1  load PC with branch target if ALU zero (gated in datapath).
- o_IRWrite  out  1  load instruction register.
- o_RegWrite  out  1  register-file write enable.
- o_MemRead  out  1  data-memory read request.
- o_MemWrite  out  1  data-memory write request.
- o_MemToReg  out  1  writeback source: 1 = memory data, 0 = ALU result.
- o_ALUSrc  out  1  ALU operand 2: 1 = immediate, 0 = rs2.
- o_ALUOp  out  2  00 add (load/store), 01 subtract (branch), 10 R-type funct, 11 I-type funct.
- o_Fault  out  1  sticky: illegal opcode or memory timeout.
- o_InstRet  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Opcode classes: R 0110011, IALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other value is illegal.
- IDLE: entered from reset. Moves to FETCH when i_Run=1.
- FETCH: o_IRWrite=1 and o_PCWrite=1 for exactly one cycle, then DECODE. If i_Run=0 on arrival, stays in IDLE instead; FETCH is never entered with i_Run low.
- DECODE: latches i_OPCode into an internal class register, which all later states use.
  - Legal opcode: go to EXECUTE.
  - Illegal opcode: go to HALT with o_Fault=1.
- EXECUTE, one cycle:
  - R: o_ALUOp=10, o_ALUSrc=0.
  - IALU: o_ALUOp=11, o_ALUSrc=1.
  - LOAD/STORE: o_ALUOp=00, o_ALUSrc=1.
  - BRANCH: o_ALUOp=01, o_ALUSrc=0, o_PCWriteCond=1.
- Next state from EXECUTE: R/IALU to WRITEBACK; LOAD/STORE to MEM; BRANCH retires and goes to FETCH (i_Run=1) or IDLE.
- MEM: holds o_MemRead (LOAD) or o_MemWrite (STORE) high every cycle until i_MemAck=1. A wait counter increments each cycle without ack.
  - Ack: LOAD goes to WRITEBACK; STORE retires.
  - Counter reaches MEM_TIMEOUT with no ack: go to HALT, o_Fault=1.
  - Ack and timeout in the same cycle: ack wins.
- WRITEBACK: o_RegWrite=1 for one cycle; o_MemToReg=1 for LOAD, 0 otherwise. Instruction retires.
- Retire: o_InstRet increments by 1 (mod 2^32, wraps 0xFFFFFFFF to 0). Next state is FETCH if i_Run=1, else IDLE.
- HALT: all enables 0, o_Fault=1. Left only by reset.
- All unlisted outputs are 0 in every state. Write enables are never asserted in HALT or IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, class register=0, wait counter=0, o_InstRet=0, o_Fault=0. All other outputs are decoded from state and are therefore 0.
- Outputs are Moore: functions of state and latched class only; no combinational path from inputs to outputs.
- Cycles per instruction, i_Run held 1:
  - BRANCH: 3.
  - R/IALU: 4.
  - STORE: 4+w.
  - LOAD: 5+w.
  - w = MEM cycles before the ack cycle (ack in the first MEM cycle gives w=0).
- Reset mid-instruction: abandons immediately and returns to IDLE. No partial retire, no counter change.
- i_Run dropping mid-instruction: does not stall the current instruction; it completes, then the FSM parks in IDLE.

## Test plan
- Reset, then i_Run=1 with R opcode 0110011 repeated: FETCH/DECODE/EXECUTE/WRITEBACK loop; o_RegWrite once per 4 cycles; o_InstRet=3 after 12 cycles.
- LOAD 0000011 with i_MemAck asserted on the 3rd MEM cycle: o_MemRead high exactly 3 cycles; WRITEBACK follows with o_MemToReg=1; 7 cycles total.
- STORE 0100011 with ack never asserted, MEM_TIMEOUT=4: o_MemWrite high 4 cycles, then HALT, o_Fault=1, enables stay 0, o_InstRet unchanged.
- Opcode 1111111 in DECODE: HALT next cycle, o_Fault=1; only reset clears it; o_Fault=0 after i_rst_n pulse.
- BRANCH 1100011: o_PCWriteCond=1 for one cycle in EXECUTE, o_ALUOp=01; next FETCH 3 cycles after the previous one.
- Preload o_InstRet near wrap by running 2^32-1 instructions, or use a force in the bench: retire wraps 0xFFFFFFFF to 0x00000000. Additionally assert i_rst_n low mid-MEM: outputs 0 asynchronously, state=IDLE.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle sequencing controller for an RV32I datapath. Steps
//            each instruction through FETCH / DECODE / EXECUTE / MEM /
//            WRITEBACK, drives the datapath enables, holds data-memory
//            requests until acknowledged, and flags illegal opcodes and
//            memory timeouts with a sticky fault that only reset clears.
// Ports    : i_clk, i_rst_n (async active-low), i_Run, i_OPCode[6:0],
//            i_MemAck; o_PCWrite, o_PCWriteCond, o_IRWrite, o_RegWrite,
//            o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc, o_ALUOp[1:0],
//            o_Fault, o_InstRet[31:0]
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16   // legal range 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_Run,
    input  logic [6:0]  i_OPCode,
    input  logic        i_MemAck,
    output logic        o_PCWrite,
    output logic        o_PCWriteCond,
    output logic        o_IRWrite,
    output logic        o_RegWrite,
    output logic        o_MemRead,
    output logic        o_MemWrite,
    output logic        o_MemToReg,
    output logic        o_ALUSrc,
    output logic [1:0]  o_ALUOp,
    output logic        o_Fault,
    output logic [31:0] o_InstRet
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // C_NONE doubles as the reset value and the "illegal opcode" result.
    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_IALU   = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5
    } class_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // Wait count value on the last MEM cycle allowed before timing out.
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    class_t      r_class;
    logic [7:0]  r_wait;
    logic [31:0] r_instret;
    logic        r_fault;

    logic        r_pc_write;
    logic        r_pc_write_cond;
    logic        r_ir_write;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;
    logic        r_alu_src;
    logic [1:0]  r_alu_op;

    class_t      w_op_class;
    state_t      w_next_state;
    class_t      w_next_class;
    logic [7:0]  w_next_wait;
    logic        w_retire;
    logic        w_fault_set;

    logic        w_pc_write;
    logic        w_pc_write_cond;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_mem_to_reg;
    logic        w_alu_src;
    logic [1:0]  w_alu_op;

    // ------------------------------------------------------------------
    // Opcode classification (only consumed in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        w_op_class = C_NONE;
        case (i_OPCode)
            c_OP_R:      w_op_class = C_R;
            c_OP_IALU:   w_op_class = C_IALU;
            c_OP_LOAD:   w_op_class = C_LOAD;
            c_OP_STORE:  w_op_class = C_STORE;
            c_OP_BRANCH: w_op_class = C_BRANCH;
            default:     w_op_class = C_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_class = r_class;
        w_next_wait  = r_wait;
        w_retire     = 1'b0;
        w_fault_set  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_Run) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_class = w_op_class;
                if (w_op_class == C_NONE) begin
                    w_next_state = S_HALT;
                    w_fault_set  = 1'b1;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (r_class)
                    C_R, C_IALU:     w_next_state = S_WRITEBACK;
                    C_LOAD, C_STORE: begin
                        w_next_state = S_MEM;
                        w_next_wait  = 8'd0;
                    end
                    C_BRANCH:        w_retire = 1'b1;
                    default: begin
                        w_next_state = S_HALT;
                        w_fault_set  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (i_MemAck) begin
                    w_next_wait = 8'd0;
                    if (r_class == C_LOAD) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next_state = S_HALT;
                    w_fault_set  = 1'b1;
                end else begin
                    w_next_wait = r_wait + 8'd1;
                end
            end
            S_WRITEBACK: begin
                w_retire = 1'b1;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_retire) begin
            w_next_state = i_Run ? S_FETCH : S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the upcoming state/class, so the registered
    // outputs are a pure function of the current state and class.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_alu_src       = 1'b0;
        w_alu_op        = 2'b00;

        case (w_next_state)
            S_FETCH: begin
                w_pc_write = 1'b1;
                w_ir_write = 1'b1;
            end
            S_EXECUTE: begin
                case (w_next_class)
                    C_R: w_alu_op = 2'b10;
                    C_IALU: begin
                        w_alu_op  = 2'b11;
                        w_alu_src = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        w_alu_op  = 2'b00;
                        w_alu_src = 1'b1;
                    end
                    C_BRANCH: begin
                        w_alu_op        = 2'b01;
                        w_pc_write_cond = 1'b1;
                    end
                    default: w_alu_op = 2'b00;
                endcase
            end
            S_MEM: begin
                w_mem_read  = (w_next_class == C_LOAD);
                w_mem_write = (w_next_class == C_STORE);
            end
            S_WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (w_next_class == C_LOAD);
            end
            default: w_alu_op = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_class         <= C_NONE;
            r_wait          <= 8'd0;
            r_instret       <= 32'd0;
            r_fault         <= 1'b0;
            r_pc_write      <= 1'b0;
            r_pc_write_cond <= 1'b0;
            r_ir_write      <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_src       <= 1'b0;
            r_alu_op        <= 2'b00;
        end else begin
            r_state         <= w_next_state;
            r_class         <= w_next_class;
            r_wait          <= w_next_wait;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            r_pc_write      <= w_pc_write;
            r_pc_write_cond <= w_pc_write_cond;
            r_ir_write      <= w_ir_write;
            r_reg_write     <= w_reg_write;
            r_mem_read      <= w_mem_read;
            r_mem_write     <= w_mem_write;
            r_mem_to_reg    <= w_mem_to_reg;
            r_alu_src       <= w_alu_src;
            r_alu_op        <= w_alu_op;
        end
    end

    assign o_PCWrite     = r_pc_write;
    assign o_PCWriteCond = r_pc_write_cond;
    assign o_IRWrite     = r_ir_write;
    assign o_RegWrite    = r_reg_write;
    assign o_MemRead     = r_mem_read;
    assign o_MemWrite    = r_mem_write;
    assign o_MemToReg    = r_mem_to_reg;
    assign o_ALUSrc      = r_alu_src;
    assign o_ALUOp       = r_alu_op;
    assign o_Fault       = r_fault;
    assign o_InstRet     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control. Each task
//            drives one scenario and compares the control vector, fault and
//            retire count cycle by cycle against hand-derived sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    // Control vector bit order:
    // [9]PCWrite [8]PCWriteCond [7]IRWrite [6]RegWrite [5]MemRead
    // [4]MemWrite [3]MemToReg [2]ALUSrc [1:0]ALUOp
    localparam logic [9:0] V_ZERO  = 10'b0000000000;
    localparam logic [9:0] V_FETCH = 10'b1010000000;
    localparam logic [9:0] V_EXR   = 10'b0000000010;
    localparam logic [9:0] V_EXI   = 10'b0000000111;
    localparam logic [9:0] V_EXLS  = 10'b0000000100;
    localparam logic [9:0] V_EXB   = 10'b0100000001;
    localparam logic [9:0] V_MEMR  = 10'b0000100000;
    localparam logic [9:0] V_MEMW  = 10'b0000010000;
    localparam logic [9:0] V_WBR   = 10'b0001000000;
    localparam logic [9:0] V_WBL   = 10'b0001001000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        ack = 1'b0;

    logic        pcw, pcwc, irw, rw, mr, mw, mtr, alusrc;
    logic [1:0]  aluop;
    logic        fault;
    logic [31:0] instret;
    logic [9:0]  ctl;

    int total = 0;
    int bad   = 0;

    assign ctl = {pcw, pcwc, irw, rw, mr, mw, mtr, alusrc, aluop};

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_Run         (run),
        .i_OPCode      (opcode),
        .i_MemAck      (ack),
        .o_PCWrite     (pcw),
        .o_PCWriteCond (pcwc),
        .o_IRWrite     (irw),
        .o_RegWrite    (rw),
        .o_MemRead     (mr),
        .o_MemWrite    (mw),
        .o_MemToReg    (mtr),
        .o_ALUSrc      (alusrc),
        .o_ALUOp       (aluop),
        .o_Fault       (fault),
        .o_InstRet     (instret)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ctl !== V_ZERO || fault !== 1'b0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL reset: ctl=%b fault=%b instret=%0d, required ctl=%b fault=0 instret=0",
                     ctl, fault, instret, V_ZERO);
        end
        // Run low: must stay parked in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== V_ZERO) begin
                bad++;
                $display("FAIL idle_hold[%0d]: ctl=%b required %b", i, ctl, V_ZERO);
            end
        end
    endtask

    task automatic test_r_loop();
        logic [9:0] seq [4];
        int rw_cnt;
        seq = '{V_FETCH, V_ZERO, V_EXR, V_WBR};
        rw_cnt = 0;
        do_reset();
        opcode = OP_R;
        run    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rw) rw_cnt++;
            total++;
            if (ctl !== seq[i % 4] || instret !== 32'(i / 4)) begin
                bad++;
                $display("FAIL r_loop[%0d]: ctl=%b instret=%0d, required ctl=%b instret=%0d",
                         i, ctl, instret, seq[i % 4], i / 4);
            end
        end
        @(negedge clk);
        total++;
        if (ctl !== V_FETCH || instret !== 32'd3 || rw_cnt != 3) begin
            bad++;
            $display("FAIL r_loop_end: ctl=%b instret=%0d regwrites=%0d, required ctl=%b instret=3 regwrites=3",
                     ctl, instret, rw_cnt, V_FETCH);
        end
    endtask

    task automatic test_ialu();
        logic [9:0] seq [5];
        logic [31:0] ret [5];
        seq = '{V_FETCH, V_ZERO, V_EXI, V_WBR, V_FETCH};
        ret = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        do_reset();
        opcode = OP_IALU;
        run    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || instret !== ret[i]) begin
                bad++;
                $display("FAIL ialu[%0d]: ctl=%b instret=%0d, required ctl=%b instret=%0d",
                         i, ctl, instret, seq[i], ret[i]);
            end
        end
    endtask

    // LOAD acked on the third MEM cycle; Run drops mid-instruction so the
    // instruction still completes and the FSM then parks in IDLE.
    task automatic test_load();
        logic [9:0] seq [9];
        logic [31:0] ret [9];
        logic ack_drv [9];
        logic run_drv [9];
        seq     = '{V_FETCH, V_ZERO, V_EXLS, V_MEMR, V_MEMR, V_MEMR, V_WBL, V_ZERO, V_ZERO};
        ret     = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        ack_drv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        run_drv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        opcode = OP_LOAD;
        run    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || instret !== ret[i] || fault !== 1'b0) begin
                bad++;
                $display("FAIL load[%0d]: ctl=%b instret=%0d fault=%b, required ctl=%b instret=%0d fault=0",
                         i, ctl, instret, fault, seq[i], ret[i]);
            end
            ack = ack_drv[i];
            run = run_drv[i];
        end
    endtask

    // STORE acked on the last allowed MEM cycle (ack beats timeout), then a
    // STORE acked on its first MEM cycle.
    task automatic test_store_ack();
        logic [9:0] seq [12];
        logic [31:0] ret [12];
        logic ack_drv [12];
        seq     = '{V_FETCH, V_ZERO, V_EXLS, V_MEMW, V_MEMW, V_MEMW, V_MEMW,
                    V_FETCH, V_ZERO, V_EXLS, V_MEMW, V_FETCH};
        ret     = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                    32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        ack_drv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        opcode = OP_STORE;
        run    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || instret !== ret[i] || fault !== 1'b0) begin
                bad++;
                $display("FAIL store_ack[%0d]: ctl=%b instret=%0d fault=%b, required ctl=%b instret=%0d fault=0",
                         i, ctl, instret, fault, seq[i], ret[i]);
            end
            ack = ack_drv[i];
        end
    endtask

    task automatic test_store_timeout();
        logic [9:0] seq [10];
        logic flt [10];
        seq = '{V_FETCH, V_ZERO, V_EXLS, V_MEMW, V_MEMW, V_MEMW, V_MEMW,
                V_ZERO, V_ZERO, V_ZERO};
        flt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        opcode = OP_STORE;
        run    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || fault !== flt[i] || instret !== 32'd0) begin
                bad++;
                $display("FAIL store_timeout[%0d]: ctl=%b fault=%b instret=%0d, required ctl=%b fault=%b instret=0",
                         i, ctl, fault, instret, seq[i], flt[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [9:0] seq [6];
        logic flt [6];
        seq = '{V_FETCH, V_ZERO, V_ZERO, V_ZERO, V_ZERO, V_ZERO};
        flt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        opcode = OP_BAD;
        run    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || fault !== flt[i]) begin
                bad++;
                $display("FAIL illegal[%0d]: ctl=%b fault=%b, required ctl=%b fault=%b",
                         i, ctl, fault, seq[i], flt[i]);
            end
        end
        do_reset();
        total++;
        if (fault !== 1'b0 || ctl !== V_ZERO) begin
            bad++;
            $display("FAIL illegal_clear: fault=%b ctl=%b, required fault=0 ctl=%b", fault, ctl, V_ZERO);
        end
    endtask

    task automatic test_back_to_back_branch();
        logic [9:0] seq [7];
        logic [31:0] ret [7];
        seq = '{V_FETCH, V_ZERO, V_EXB, V_FETCH, V_ZERO, V_EXB, V_FETCH};
        ret = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
        do_reset();
        opcode = OP_BRANCH;
        run    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== seq[i] || instret !== ret[i]) begin
                bad++;
                $display("FAIL branch[%0d]: ctl=%b instret=%0d, required ctl=%b instret=%0d",
                         i, ctl, instret, seq[i], ret[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        opcode = OP_R;
        run    = 1'b1;
        @(negedge clk);    // FETCH
        @(negedge clk);    // DECODE
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        @(negedge clk);    // EXECUTE
        @(negedge clk);    // WRITEBACK
        total++;
        if (ctl !== V_WBR || instret !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_pre: ctl=%b instret=%h, required ctl=%b instret=ffffffff",
                     ctl, instret, V_WBR);
        end
        @(negedge clk);    // FETCH after retire
        total++;
        if (ctl !== V_FETCH || instret !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap: ctl=%b instret=%h, required ctl=%b instret=00000000",
                     ctl, instret, V_FETCH);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        opcode = OP_R;
        run    = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        opcode = OP_LOAD;
        for (int i = 0; i < 4; i++) @(negedge clk);
        total++;
        if (ctl !== V_MEMR || instret !== 32'd1) begin
            bad++;
            $display("FAIL mid_mem_pre: ctl=%b instret=%0d, required ctl=%b instret=1",
                     ctl, instret, V_MEMR);
        end
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        total++;
        if (ctl !== V_ZERO || instret !== 32'd0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL mid_mem_async: ctl=%b instret=%0d fault=%b, required ctl=%b instret=0 fault=0",
                     ctl, instret, fault, V_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== V_ZERO) begin
            bad++;
            $display("FAIL mid_mem_idle: ctl=%b required %b", ctl, V_ZERO);
        end
        run = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== V_FETCH || instret !== 32'd0) begin
            bad++;
            $display("FAIL mid_mem_refetch: ctl=%b instret=%0d, required ctl=%b instret=0",
                     ctl, instret, V_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_r_loop();
        test_ialu();
        test_load();
        test_store_ack();
        test_store_timeout();
        test_illegal();
        test_back_to_back_branch();
        test_wrap();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
